// File: rtl/l2_mem_ctrl_if.sv
// l2_mem_ctrl_if: L2-side line request signals and bmem-side burst signals for the memory controller
interface l2_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64
);
    logic [ADDR_WIDTH-1:0] l2cache_addr;
    logic                  l2cache_read;
    logic                  l2cache_write;
    logic [LINE_BITS-1:0]  l2cache_wdata;
    logic [LINE_BITS-1:0]  l2cache_rdata;
    logic                  l2cache_resp;
    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_BITS-1:0]  bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [BEAT_BITS-1:0]  bmem_rdata;
    logic                  bmem_rvalid;

    modport master (
        input  l2cache_addr, l2cache_read, l2cache_write, l2cache_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output l2cache_rdata, l2cache_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport slave (
        output l2cache_addr, l2cache_read, l2cache_write, l2cache_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  l2cache_rdata, l2cache_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/l2_mem_ctrl.sv
// l2_mem_ctrl: splits L2 line writebacks into bmem write beats and assembles read beats into line fills
module l2_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64
) (
    input  logic              clk,
    input  logic              rst,
    l2_mem_ctrl_if.master     io_bus
);
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CW    = $clog2(BEATS);
    localparam int OFS   = $clog2(LINE_BITS / 8);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_BEAT, RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_buf;
    logic [LINE_BITS-1:0]  r_rdata;
    logic                  w_last;
    logic                  w_beat_hit;
    logic                  w_wr_acc;

    assign w_last     = r_cnt == CW'(BEATS - 1);
    assign w_beat_hit = r_state == RD_DATA && io_bus.bmem_rvalid && io_bus.bmem_raddr == r_addr;
    assign w_wr_acc   = r_state == WR_BEAT && io_bus.bmem_ready;

    // state register; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    // next state and bus outputs; writes win over reads, a held read is picked up after RESP
    always_comb begin
        w_next               = r_state;
        io_bus.bmem_read     = r_state == RD_REQ;
        io_bus.bmem_write    = r_state == WR_BEAT;
        io_bus.bmem_addr     = (r_state == RD_REQ || r_state == WR_BEAT) ? r_addr : '0;
        io_bus.bmem_wdata    = r_state == WR_BEAT ? r_wdata[BEAT_BITS*int'(r_cnt) +: BEAT_BITS] : '0;
        io_bus.l2cache_resp  = r_state == RESP;
        io_bus.l2cache_rdata = r_rdata;
        case (r_state)
            IDLE:    w_next = io_bus.l2cache_write ? WR_BEAT : io_bus.l2cache_read ? RD_REQ : IDLE;
            RD_REQ:  w_next = io_bus.bmem_ready ? RD_DATA : RD_REQ;
            RD_DATA: w_next = (w_beat_hit && w_last) ? RESP : RD_DATA;
            WR_BEAT: w_next = (w_wr_acc && w_last) ? RESP : WR_BEAT;
            default: w_next = IDLE;
        endcase
    end

    // datapath: latch request, step beat counter, assemble fill and publish it only when complete
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && (io_bus.l2cache_write || io_bus.l2cache_read))
                r_addr <= {io_bus.l2cache_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
            if (r_state == IDLE && io_bus.l2cache_write)
                r_wdata <= io_bus.l2cache_wdata;
            if (r_state == RD_REQ)
                r_cnt <= '0;
            else if (w_wr_acc || w_beat_hit)
                r_cnt <= r_cnt + 1'b1;
            if (w_beat_hit)
                r_buf[BEAT_BITS*int'(r_cnt) +: BEAT_BITS] <= io_bus.bmem_rdata;
            if (w_beat_hit && w_last)
                r_rdata <= {io_bus.bmem_rdata, r_buf[LINE_BITS-BEAT_BITS-1:0]};
        end
    end
endmodule

// File: tb/tb_l2_mem_ctrl.sv
// tb_l2_mem_ctrl: directed scenario tests for l2_mem_ctrl
module tb_l2_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   resp_cnt = 0;
    int   d1_cycles = 0;
    logic [63:0] wr_q[$];
    logic [63:0] d1_val = 64'hD1D1_1111_2222_3333;

    l2_mem_ctrl_if bus();

    l2_mem_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // observe resp pulses and accepted write beats mid-cycle
    always @(negedge clk) begin
        if (bus.l2cache_resp) resp_cnt <= resp_cnt + 1;
        if (bus.bmem_write && bus.bmem_ready) wr_q.push_back(bus.bmem_wdata);
        if (bus.bmem_write && bus.bmem_wdata == d1_val) d1_cycles <= d1_cycles + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] ra, input logic [63:0] d);
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = ra;
        bus.bmem_rdata  = d;
        cyc();
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.l2cache_addr = '0; bus.l2cache_read = 0; bus.l2cache_write = 0; bus.l2cache_wdata = '0;
        bus.bmem_ready = 0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 0;
        cyc(); cyc();
        n_chk++; if (bus.l2cache_resp !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 0", bus.l2cache_resp); end
        n_chk++; if (bus.l2cache_rdata !== 256'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.l2cache_rdata); end
        n_chk++; if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0) begin n_fail++; $display("FAIL rst_rw: got %b%b want 00", bus.bmem_read, bus.bmem_write); end
        n_chk++; if (bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== 64'h0) begin n_fail++; $display("FAIL rst_addr_wdata: got %h %h want 0 0", bus.bmem_addr, bus.bmem_wdata); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_read_b2b();
        logic [63:0] a [4];
        int base;
        a[0] = 64'hA000_0000_0000_00A0; a[1] = 64'hA111_1111_1111_11A1;
        a[2] = 64'hA222_2222_2222_22A2; a[3] = 64'hA333_3333_3333_33A3;
        base = resp_cnt;
        bus.l2cache_addr = 32'h0000_1040; bus.l2cache_read = 1; bus.bmem_ready = 1;
        cyc();
        n_chk++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL rd_req: got read=%b addr=%h want 1 00001040", bus.bmem_read, bus.bmem_addr); end
        cyc();
        n_chk++; if (bus.bmem_read !== 1'b0 || bus.bmem_addr !== 32'h0) begin n_fail++; $display("FAIL rd_req_once: got read=%b addr=%h want 0 0", bus.bmem_read, bus.bmem_addr); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.l2cache_resp !== 1'b0) begin n_fail++; $display("FAIL rd_early_resp beat %0d: got 1 want 0", i); end
            send_beat(32'h0000_1040, a[i]);
        end
        n_chk++; if (bus.l2cache_resp !== 1'b1) begin n_fail++; $display("FAIL rd_resp: got %b want 1", bus.l2cache_resp); end
        n_chk++; if (bus.l2cache_rdata !== {a[3], a[2], a[1], a[0]}) begin n_fail++; $display("FAIL rd_rdata: got %h want %h", bus.l2cache_rdata, {a[3], a[2], a[1], a[0]}); end
        bus.l2cache_read = 0;
        cyc();
        n_chk++; if (bus.l2cache_resp !== 1'b0 || resp_cnt - base != 1) begin n_fail++; $display("FAIL rd_resp_pulse: got resp=%b count=%0d want 0 1", bus.l2cache_resp, resp_cnt - base); end
        n_chk++; if (bus.l2cache_rdata !== {a[3], a[2], a[1], a[0]}) begin n_fail++; $display("FAIL rd_rdata_hold: got %h", bus.l2cache_rdata); end
    endtask

    task automatic test_write_stall();
        logic [63:0] d [4];
        int base;
        int qb;
        d[0] = 64'hD0D0_0000_1111_0000; d[1] = d1_val;
        d[2] = 64'hD2D2_2222_3333_4444; d[3] = 64'hD3D3_3333_4444_5555;
        base = resp_cnt; qb = wr_q.size(); d1_cycles = 0;
        bus.l2cache_addr = 32'h0000_2000; bus.l2cache_write = 1; bus.l2cache_wdata = {d[3], d[2], d[1], d[0]}; bus.bmem_ready = 1;
        cyc();
        n_chk++; if (bus.bmem_write !== 1'b1 || bus.bmem_read !== 1'b0 || bus.bmem_addr !== 32'h0000_2000 || bus.bmem_wdata !== d[0]) begin n_fail++; $display("FAIL wr_beat0: got w=%b r=%b addr=%h data=%h want 1 0 00002000 %h", bus.bmem_write, bus.bmem_read, bus.bmem_addr, bus.bmem_wdata, d[0]); end
        cyc();
        bus.bmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.bmem_wdata !== d[1]) begin n_fail++; $display("FAIL wr_hold cycle %0d: got %h want %h", i, bus.bmem_wdata, d[1]); end
            if (i < 3) cyc();
        end
        bus.bmem_ready = 1;
        cyc();
        n_chk++; if (bus.bmem_wdata !== d[2]) begin n_fail++; $display("FAIL wr_beat2: got %h want %h", bus.bmem_wdata, d[2]); end
        cyc();
        cyc();
        n_chk++; if (bus.l2cache_resp !== 1'b1 || bus.bmem_write !== 1'b0) begin n_fail++; $display("FAIL wr_resp: got resp=%b w=%b want 1 0", bus.l2cache_resp, bus.bmem_write); end
        bus.l2cache_write = 0;
        cyc(); cyc();
        n_chk++; if (resp_cnt - base != 1) begin n_fail++; $display("FAIL wr_resp_count: got %0d want 1", resp_cnt - base); end
        n_chk++; if (d1_cycles != 4) begin n_fail++; $display("FAIL wr_d1_cycles: got %0d want 4", d1_cycles); end
        n_chk++;
        if (wr_q.size() - qb != 4) begin n_fail++; $display("FAIL wr_beat_count: got %0d want 4", wr_q.size() - qb); end
        else if (wr_q[qb] !== d[0] || wr_q[qb+1] !== d[1] || wr_q[qb+2] !== d[2] || wr_q[qb+3] !== d[3]) begin
            n_fail++; $display("FAIL wr_order: got %h %h %h %h", wr_q[qb], wr_q[qb+1], wr_q[qb+2], wr_q[qb+3]);
        end
    endtask

    task automatic test_read_gaps();
        logic [63:0] b [4];
        int base;
        b[0] = 64'hB000_0000_0000_0B00; b[1] = 64'hB111_0000_0000_0B11;
        b[2] = 64'hB222_0000_0000_0B22; b[3] = 64'hB333_0000_0000_0B33;
        base = resp_cnt;
        bus.l2cache_addr = 32'h0000_5000; bus.l2cache_read = 1; bus.bmem_ready = 1;
        cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (5) cyc();
            send_beat(32'h0000_5000, b[i]);
            if (i == 1) send_beat(32'h0000_3000, 64'hDEAD_BEEF_DEAD_BEEF);
        end
        n_chk++; if (bus.l2cache_resp !== 1'b1) begin n_fail++; $display("FAIL gap_resp: got %b want 1", bus.l2cache_resp); end
        n_chk++; if (bus.l2cache_rdata !== {b[3], b[2], b[1], b[0]}) begin n_fail++; $display("FAIL gap_rdata: got %h want %h", bus.l2cache_rdata, {b[3], b[2], b[1], b[0]}); end
        bus.l2cache_read = 0;
        cyc(); cyc();
        n_chk++; if (resp_cnt - base != 1) begin n_fail++; $display("FAIL gap_resp_count: got %0d want 1", resp_cnt - base); end
    endtask

    task automatic test_rw_both();
        logic [63:0] c [4];
        int base;
        c[0] = 64'hC000_0000_0000_00C0; c[1] = 64'hC111_0000_0000_00C1;
        c[2] = 64'hC222_0000_0000_00C2; c[3] = 64'hC333_0000_0000_00C3;
        base = resp_cnt;
        bus.l2cache_addr = 32'h0000_0100; bus.l2cache_read = 1; bus.l2cache_write = 1;
        bus.l2cache_wdata = {4{64'h5A5A_0000_0000_A5A5}}; bus.bmem_ready = 1;
        cyc();
        n_chk++; if (bus.bmem_write !== 1'b1 || bus.bmem_read !== 1'b0 || bus.bmem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL both_write_first: got w=%b r=%b addr=%h want 1 0 00000100", bus.bmem_write, bus.bmem_read, bus.bmem_addr); end
        repeat (4) cyc();
        n_chk++; if (bus.l2cache_resp !== 1'b1) begin n_fail++; $display("FAIL both_wr_resp: got %b want 1", bus.l2cache_resp); end
        bus.l2cache_write = 0;
        cyc(); cyc();
        n_chk++; if (bus.bmem_read !== 1'b1 || bus.bmem_write !== 1'b0 || bus.bmem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL both_rd_req: got r=%b w=%b addr=%h want 1 0 00000100", bus.bmem_read, bus.bmem_write, bus.bmem_addr); end
        cyc();
        for (int i = 0; i < 4; i++) send_beat(32'h0000_0100, c[i]);
        n_chk++; if (bus.l2cache_resp !== 1'b1 || bus.l2cache_rdata !== {c[3], c[2], c[1], c[0]}) begin n_fail++; $display("FAIL both_rd_resp: got resp=%b rdata=%h", bus.l2cache_resp, bus.l2cache_rdata); end
        bus.l2cache_read = 0;
        cyc(); cyc();
        n_chk++; if (resp_cnt - base != 2) begin n_fail++; $display("FAIL both_resp_count: got %0d want 2", resp_cnt - base); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] f [4];
        int base;
        f[0] = 64'hF000_0000_0000_00F0; f[1] = 64'hF111_0000_0000_00F1;
        f[2] = 64'hF222_0000_0000_00F2; f[3] = 64'hF333_0000_0000_00F3;
        bus.l2cache_addr = 32'h0000_6000; bus.l2cache_read = 1; bus.bmem_ready = 1;
        cyc(); cyc();
        send_beat(32'h0000_6000, 64'h1111_0000_0000_0000);
        send_beat(32'h0000_6000, 64'h2222_0000_0000_0000);
        base = resp_cnt;
        rst = 1; bus.l2cache_read = 0;
        cyc();
        rst = 0;
        n_chk++; if (bus.l2cache_rdata !== 256'h0 || bus.l2cache_resp !== 1'b0 || bus.bmem_read !== 1'b0 || bus.bmem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_outputs: got rdata=%h resp=%b r=%b addr=%h want all 0", bus.l2cache_rdata, bus.l2cache_resp, bus.bmem_read, bus.bmem_addr); end
        send_beat(32'h0000_6000, 64'h3333_0000_0000_0000);
        send_beat(32'h0000_6000, 64'h4444_0000_0000_0000);
        cyc();
        n_chk++; if (resp_cnt != base || bus.l2cache_rdata !== 256'h0) begin n_fail++; $display("FAIL midrst_stale: got resps=%0d rdata=%h want 0 0", resp_cnt - base, bus.l2cache_rdata); end
        bus.l2cache_read = 1;
        cyc(); cyc();
        for (int i = 0; i < 4; i++) send_beat(32'h0000_6000, f[i]);
        n_chk++; if (bus.l2cache_resp !== 1'b1 || bus.l2cache_rdata !== {f[3], f[2], f[1], f[0]}) begin n_fail++; $display("FAIL midrst_next_read: got resp=%b rdata=%h want 1 %h", bus.l2cache_resp, bus.l2cache_rdata, {f[3], f[2], f[1], f[0]}); end
        bus.l2cache_read = 0;
        cyc();
    endtask

    task automatic test_unaligned();
        bus.l2cache_addr = 32'h0000_105F; bus.l2cache_read = 1; bus.bmem_ready = 1;
        cyc();
        n_chk++; if (bus.bmem_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL unaligned_addr: got %h want 00001040", bus.bmem_addr); end
        cyc();
        for (int i = 0; i < 4; i++) send_beat(32'h0000_1040, 64'(i + 1));
        n_chk++; if (bus.l2cache_resp !== 1'b1 || bus.l2cache_rdata !== {64'd4, 64'd3, 64'd2, 64'd1}) begin n_fail++; $display("FAIL unaligned_fill: got resp=%b rdata=%h", bus.l2cache_resp, bus.l2cache_rdata); end
        bus.l2cache_read = 0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_read_b2b();
        test_write_stall();
        test_read_gaps();
        test_rw_both();
        test_reset_mid();
        test_unaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
